// File: rtl/clkdiv_phase_ctrl_pkg.sv
// Shared types and reset defaults for the PHI2 clock divider / phase controller.
package clkdiv_pkg;

    localparam int DIV_W_DEF       = 4;
    localparam int RST_DIV_DEF     = 3;
    localparam int MAX_STRETCH_DEF = 7;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_HIGH    = 2'd1,
        ST_STOP    = 2'd2,
        ST_STRETCH = 2'd3
    } clk_state_e;

endpackage

// File: rtl/clkdiv_phase_ctrl_if.sv
// Control/status bundle between the CPU clock mux side (master) and the divider (slave).
interface clkdiv_phase_ctrl_if
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic [DIV_W-1:0] div_sel;
    logic             div_req;
    logic             div_ack;
    logic [DIV_W-1:0] cur_div;
    logic             stop_req;
    logic             stopped;
    logic             stretch_req;
    logic             clkout;
    logic             phi2_end_nxt;
    logic             phi2_start_nxt;

    modport master (
        output div_sel, div_req, stop_req, stretch_req,
        input  div_ack, cur_div, stopped, clkout, phi2_end_nxt, phi2_start_nxt
    );

    modport slave (
        input  div_sel, div_req, stop_req, stretch_req,
        output div_ack, cur_div, stopped, clkout, phi2_end_nxt, phi2_start_nxt
    );
endinterface

// File: rtl/clkdiv_phase_ctrl_half_cnt.sv
// Half-period counter: counts 0..lim, clears on request, flags the terminal count.
module clkdiv_half_cnt #(
    parameter int W = 4
) (
    input  logic         hsclk_in,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] lim,
    output logic         term
);
    logic [W-1:0] cnt;

    always_ff @(posedge hsclk_in) begin
        if (rst || clr) cnt <= '0;
        else            cnt <= cnt + W'(1);
    end

    assign term = (cnt == lim);
endmodule

// File: rtl/clkdiv_phase_ctrl.sv
// Registered glitch-free PHI2 clock generator with req/ack divisor handover and stop.
// Optional PHI2 stretching is built only when CLKDIV_STRETCH_EN is defined.
module clkdiv_phase_ctrl
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int RST_DIV     = RST_DIV_DEF,
    parameter int MAX_STRETCH = MAX_STRETCH_DEF
) (
    input  logic                hsclk_in,
    input  logic                rst,
    clkdiv_phase_ctrl_if.slave  bus
);
    clk_state_e       state, state_nxt;
    logic             term, cnt_clr;
    logic             boundary, take, armed;
    logic             clkout_q, div_ack_q;
    logic [DIV_W-1:0] cur_div_q;

    clkdiv_half_cnt #(.W(DIV_W)) u_half_cnt (
        .hsclk_in (hsclk_in),
        .rst      (rst),
        .clr      (cnt_clr),
        .lim      (cur_div_q),
        .term     (term)
    );

    assign boundary = (state == ST_HIGH) && term;
    // A held div_req is acknowledged once; it must be seen low before it can re-arm.
    assign take     = boundary && bus.div_req && armed;

`ifdef CLKDIV_STRETCH_EN
    localparam int SW = $clog2(MAX_STRETCH + 1);
    logic [SW-1:0] scnt;
    logic          st_exit;

    assign st_exit = !bus.stretch_req || (scnt == SW'(MAX_STRETCH));
`else
    logic unused_stretch;
    assign unused_stretch = bus.stretch_req & (MAX_STRETCH > 0);
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        case (state)
            ST_LOW: begin
                if (term) begin
                    state_nxt = ST_HIGH;
                    cnt_clr   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (term) begin
                    cnt_clr = 1'b1;
                    if (bus.stop_req)         state_nxt = ST_STOP;
`ifdef CLKDIV_STRETCH_EN
                    else if (bus.stretch_req) state_nxt = ST_STRETCH;
`endif
                    else                      state_nxt = ST_LOW;
                end
            end
            ST_STOP: begin
                cnt_clr = 1'b1;
                if (!bus.stop_req) state_nxt = ST_LOW;
            end
`ifdef CLKDIV_STRETCH_EN
            ST_STRETCH: begin
                cnt_clr = 1'b1;
                if (st_exit) state_nxt = bus.stop_req ? ST_STOP : ST_LOW;
            end
`endif
            default: begin
                state_nxt = ST_LOW;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // clkout is the registered image of "next state is not LOW", so it never glitches.
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            state     <= ST_LOW;
            clkout_q  <= 1'b0;
            cur_div_q <= DIV_W'(RST_DIV);
            div_ack_q <= 1'b0;
            armed     <= 1'b1;
        end else begin
            state     <= state_nxt;
            clkout_q  <= (state_nxt != ST_LOW);
            div_ack_q <= take;
            if (take)              cur_div_q <= bus.div_sel;
            if (take)              armed     <= 1'b0;
            else if (!bus.div_req) armed     <= 1'b1;
        end
    end

`ifdef CLKDIV_STRETCH_EN
    always_ff @(posedge hsclk_in) begin
        if (rst)                                             scnt <= '0;
        else if (state == ST_HIGH && state_nxt == ST_STRETCH) scnt <= SW'(1);
        else if (state == ST_STRETCH)                        scnt <= scnt + SW'(1);
    end
`endif

    assign bus.clkout         = clkout_q;
    assign bus.div_ack        = div_ack_q;
    assign bus.cur_div        = cur_div_q;
    assign bus.stopped        = (state == ST_STOP);
    assign bus.phi2_start_nxt = (state == ST_LOW) && term;
    assign bus.phi2_end_nxt   = (state != ST_LOW) && (state_nxt == ST_LOW);
endmodule

// File: tb/tb_clkdiv_phase_ctrl.sv
// Directed bench for clkdiv_phase_ctrl: vector table for divide/handover, hand sequences
// for stop, stretch (CLKDIV_STRETCH_EN) and reset in parked states.
module tb_clkdiv_phase_ctrl;
    localparam int MAX_ST = 7;
`ifdef CLKDIV_STRETCH_EN
    localparam int EXP_LONG  = 2 + MAX_ST;
    localparam int EXP_THREE = 5;
`else
    localparam int EXP_LONG  = 2;
    localparam int EXP_THREE = 2;
`endif

    logic hsclk_in = 1'b0;
    logic rst      = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    clkdiv_phase_ctrl_if bus ();

    clkdiv_phase_ctrl dut (
        .hsclk_in (hsclk_in),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 hsclk_in = ~hsclk_in;

    typedef struct {
        logic [3:0] sel;
        logic       req;
        logic       e_clk;
        logic       e_ack;
        logic [3:0] e_cur;
        logic       e_end;
        logic       e_start;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t v(int sel, int req, int clk, int ack, int cur, int en, int st);
        vec_t r;
        r.sel = 4'(sel); r.req = 1'(req); r.e_clk = 1'(clk); r.e_ack = 1'(ack);
        r.e_cur = 4'(cur); r.e_end = 1'(en); r.e_start = 1'(st);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge hsclk_in);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge hsclk_in);
        rst = 1'b1;
        bus.div_sel = '0; bus.div_req = 1'b0; bus.stop_req = 1'b0; bus.stretch_req = 1'b0;
        repeat (2) @(posedge hsclk_in);
        @(negedge hsclk_in);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_rise(input string nm);
        for (int i = 0; i < 40 && !bus.clkout; i++) cyc();
        chk(nm, bus.clkout, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // cycle index after reset:  sel req | clk ack cur end start
        tbl[0]  = v(7,0, 0,0,3,0,0); tbl[1]  = v(7,0, 0,0,3,0,0); tbl[2]  = v(7,0, 0,0,3,0,1);
        tbl[3]  = v(7,0, 1,0,3,0,0); tbl[4]  = v(7,0, 1,0,3,0,0); tbl[5]  = v(7,0, 1,0,3,0,0);
        tbl[6]  = v(7,0, 1,0,3,1,0); tbl[7]  = v(1,0, 0,0,3,0,0); tbl[8]  = v(1,1, 0,0,3,0,0);
        tbl[9]  = v(1,1, 0,0,3,0,0); tbl[10] = v(1,1, 0,0,3,0,1); tbl[11] = v(1,1, 1,0,3,0,0);
        tbl[12] = v(1,1, 1,0,3,0,0); tbl[13] = v(1,1, 1,0,3,0,0); tbl[14] = v(1,1, 1,0,3,1,0);
        tbl[15] = v(1,1, 0,1,1,0,0); tbl[16] = v(1,1, 0,0,1,0,1); tbl[17] = v(1,1, 1,0,1,0,0);
        tbl[18] = v(1,1, 1,0,1,1,0); tbl[19] = v(1,0, 0,0,1,0,0); tbl[20] = v(0,0, 0,0,1,0,1);
        tbl[21] = v(0,1, 1,0,1,0,0); tbl[22] = v(0,1, 1,0,1,1,0); tbl[23] = v(0,0, 0,1,0,0,1);
        tbl[24] = v(0,0, 1,0,0,1,0); tbl[25] = v(0,0, 0,0,0,0,1); tbl[26] = v(0,0, 1,0,0,1,0);

        bus.div_sel = '0; bus.div_req = 1'b0; bus.stop_req = 1'b0; bus.stretch_req = 1'b0;
        reset_dut();
        chk("rst_clkout", bus.clkout, 0);
        chk("rst_cur_div", bus.cur_div, 3);
        chk("rst_ack", bus.div_ack, 0);
        chk("rst_stopped", bus.stopped, 0);
        chk("rst_start", bus.phi2_start_nxt, 0);
        chk("rst_end", bus.phi2_end_nxt, 0);

        // divide-by-8, ignored div_sel, handover to h=2, held req, handover to h=1
        for (int i = 0; i < 27; i++) begin
            @(negedge hsclk_in);
            bus.div_sel = tbl[i].sel;
            bus.div_req = tbl[i].req;
            #1;
            chk($sformatf("vec%0d_clkout", i + 1), bus.clkout, tbl[i].e_clk);
            chk($sformatf("vec%0d_ack", i + 1), bus.div_ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_cur_div", i + 1), bus.cur_div, tbl[i].e_cur);
            chk($sformatf("vec%0d_end", i + 1), bus.phi2_end_nxt, tbl[i].e_end);
            chk($sformatf("vec%0d_start", i + 1), bus.phi2_start_nxt, tbl[i].e_start);
            chk($sformatf("vec%0d_stopped", i + 1), bus.stopped, 0);
        end

        // stop requested from reset: parks at the end of the first PHI2
        reset_dut();
        bus.stop_req = 1'b1;
        repeat (7) cyc();
        chk("stop_bnd_clkout", bus.clkout, 1);
        chk("stop_bnd_end", bus.phi2_end_nxt, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("stop_hold%0d_clkout", k), bus.clkout, 1);
            chk($sformatf("stop_hold%0d_stopped", k), bus.stopped, 1);
        end
        cyc();
        bus.stop_req = 1'b0;
        #1;
        chk("stop_rel_end", bus.phi2_end_nxt, 1);
        chk("stop_rel_clkout", bus.clkout, 1);
        cyc();
        chk("stop_after_clkout", bus.clkout, 0);
        chk("stop_after_stopped", bus.stopped, 0);

        // stop + stretch + div_req together at the boundary, then reset while parked
        reset_dut();
        bus.stop_req = 1'b1; bus.stretch_req = 1'b1; bus.div_sel = 4'd2; bus.div_req = 1'b1;
        repeat (8) cyc();
        chk("combo_ack", bus.div_ack, 1);
        chk("combo_cur_div", bus.cur_div, 2);
        chk("combo_stopped", bus.stopped, 1);
        chk("combo_clkout", bus.clkout, 1);
        bus.div_req = 1'b0;
        cyc();
        chk("combo_ack_off", bus.div_ack, 0);
        chk("combo_still_stopped", bus.stopped, 1);
        rst = 1'b1;
        cyc();
        chk("rst_in_stop_clkout", bus.clkout, 0);
        chk("rst_in_stop_cur_div", bus.cur_div, 3);
        chk("rst_in_stop_stopped", bus.stopped, 0);
        rst = 1'b0; bus.stop_req = 1'b0; bus.stretch_req = 1'b0;

        // h=2 then PHI2 stretching
        reset_dut();
        bus.div_sel = 4'd1; bus.div_req = 1'b1;
        for (int i = 0; i < 40 && !bus.div_ack; i++) cyc();
        chk("st_ack_seen", bus.div_ack, 1);
        chk("st_cur_div", bus.cur_div, 1);
        bus.div_req = 1'b0;
        bus.stretch_req = 1'b1;
        wait_rise("st_long_rise");
        n = 0;
        for (int i = 0; i < 40 && bus.clkout; i++) begin n++; cyc(); end
        chk("st_long_phi2_len", n, EXP_LONG);
        bus.stretch_req = 1'b0;

        wait_rise("st_three_rise");
        bus.stretch_req = 1'b1;
        n = 1;
        for (int k = 2; k <= 8; k++) begin
            cyc();
            if (k == 5) begin
                bus.stretch_req = 1'b0;
                #1;
`ifdef CLKDIV_STRETCH_EN
                chk("st_three_end", bus.phi2_end_nxt, 1);
`endif
            end
            if (!bus.clkout) break;
            n++;
        end
        chk("st_three_phi2_len", n, EXP_THREE);
        bus.stretch_req = 1'b0;

`ifdef CLKDIV_STRETCH_EN
        bus.stretch_req = 1'b1;
        wait_rise("st_rst_rise");
        repeat (2) cyc();
        chk("st_rst_in_stretch", bus.clkout, 1);
        rst = 1'b1;
        cyc();
        chk("rst_in_stretch_clkout", bus.clkout, 0);
        chk("rst_in_stretch_cur_div", bus.cur_div, 3);
        rst = 1'b0; bus.stretch_req = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
